// File: rtl/tap_delay.sv
// Programmable tap delay line: circular buffer with FILL/RUN alignment tracking.
// Optional macro TAP_DELAY_ERR_EN enables the del_err pulse on rejected loads.
module tap_delay #(
    parameter int unsigned WIDTH       = 36,
    parameter int unsigned MAX_DEL     = 16,
    parameter int unsigned DEL_W       = 5,
    parameter int unsigned DEFAULT_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [DEL_W-1:0] del_sel,
    input  logic             del_load,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             del_busy,
    output logic             del_err
);

    localparam int unsigned AW = $clog2(MAX_DEL);
    localparam int unsigned CW = $clog2(MAX_DEL + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DEL_W-1:0] del_q, del_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0]    wp_q, wp_d, wp_inc, rd_idx;
    logic [WIDTH-1:0] dout_q, dout_d, rd_data;
    logic [31:0]      rd_sum;
    logic             load_ok;

    logic [WIDTH-1:0] mem [MAX_DEL];

    // Sample storage; contents are masked by FILL so no reset is needed
    always_ff @(posedge clk) begin
        if (en) begin
            mem[wp_q] <= din;
        end
    end

    // Read tap sits D-1 entries behind the slot being written this edge
    always_comb begin
        rd_sum = 32'(wp_q) + MAX_DEL + 32'd1 - 32'(del_q);
        if (rd_sum >= MAX_DEL) begin
            rd_sum = rd_sum - MAX_DEL;
        end
        rd_idx  = AW'(rd_sum);
        rd_data = (32'(del_q) == 32'd1) ? din : mem[rd_idx];
    end

    assign wp_inc  = (32'(wp_q) == MAX_DEL - 32'd1) ? '0 : wp_q + AW'(1);
    assign cnt_inc = (32'(cnt_q) >= MAX_DEL) ? cnt_q : cnt_q + CW'(1);
    assign load_ok = del_load && (del_sel != '0) && (32'(del_sel) <= MAX_DEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            del_q   <= DEL_W'(DEFAULT_DEL);
            cnt_q   <= '0;
            wp_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            del_q   <= del_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state: an accepted load always restarts the fill, even with en=0
    always_comb begin
        state_d = state_q;
        del_d   = del_q;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        dout_d  = dout_q;
        if (en) begin
            wp_d = wp_inc;
        end
        if (load_ok) begin
            del_d   = del_sel;
            cnt_d   = '0;
            state_d = FILL;
            dout_d  = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
            if (state_q == RUN) begin
                dout_d = rd_data;
            end else if (32'(cnt_inc) >= 32'(del_q)) begin
                state_d = RUN;
                dout_d  = rd_data;
            end else begin
                dout_d = '0;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = (state_q == RUN);
    assign del_busy = (state_q == FILL);

`ifdef TAP_DELAY_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= del_load && !load_ok;
        end
    end

    assign del_err = err_q;
`else
    assign del_err = 1'b0;
`endif

endmodule

// File: tb/tb_tap_delay.sv
// Scoreboard bench for tap_delay: a sample-history model pushes expected outputs per cycle.
module tb_tap_delay;

    localparam int unsigned WIDTH   = 36;
    localparam int unsigned MAX_DEL = 16;
    localparam int unsigned DEL_W   = 5;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] din;
    logic [DEL_W-1:0] del_sel;
    logic             del_load;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             del_busy;
    logic             del_err;

    tap_delay #(
        .WIDTH(WIDTH), .MAX_DEL(MAX_DEL), .DEL_W(DEL_W), .DEFAULT_DEL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .del_sel(del_sel),
        .del_load(del_load), .dout(dout), .dout_vld(dout_vld),
        .del_busy(del_busy), .del_err(del_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic             vld;
        logic             busy;
        logic             err;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] hist[$];
    int               m_del;
    int               m_cnt;
    bit               m_run;
    logic [WIDTH-1:0] m_dout;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] seq;
    bit               err_en;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_del  = 1;
        m_cnt  = 0;
        m_run  = 1'b0;
        m_dout = '0;
        hist.delete();
        sb.delete();
    endfunction

    // Drive one cycle, predict the post-edge outputs, then compare after the edge
    task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic ld,
                        input logic [DEL_W-1:0] sel);
        exp_t x;
        bit   ok;
        @(negedge clk);
        en = e; din = d; del_load = ld; del_sel = sel;
        ok = ld && (sel >= 1) && (int'(sel) <= int'(MAX_DEL));
        if (e) hist.push_back(d);
        if (ok) begin
            m_del  = int'(sel);
            m_cnt  = 0;
            m_run  = 1'b0;
            m_dout = '0;
        end else if (e) begin
            if (m_cnt < int'(MAX_DEL)) m_cnt++;
            if (!m_run && m_cnt >= m_del) m_run = 1'b1;
            if (m_run && hist.size() >= m_del) m_dout = hist[hist.size() - m_del];
            else m_dout = '0;
        end
        x.dout = m_dout;
        x.vld  = m_run;
        x.busy = !m_run;
        x.err  = err_en && ld && !ok;
        sb.push_back(x);
        @(posedge clk);
        #1;
        del_load = 1'b0;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            x = sb.pop_front();
            check_eq("dout", 64'(dout), 64'(x.dout));
            check_eq("dout_vld", 64'(dout_vld), 64'(x.vld));
            check_eq("del_busy", 64'(del_busy), 64'(x.busy));
            check_eq("del_err", 64'(del_err), 64'(x.err));
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; del_load = 1'b0;
        #1;
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_vld", 64'(dout_vld), 64'd0);
        check_eq("rst_busy", 64'(del_busy), 64'd1);
        check_eq("rst_err", 64'(del_err), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef TAP_DELAY_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        rst_n = 1'b0; en = 1'b0; din = '0; del_sel = '0; del_load = 1'b0;
        model_reset();
        do_reset();

        // Default delay 1 after reset
        for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i), 1'b0, '0);

        // Delay 3
        step(1'b0, '0, 1'b1, 5'd3);
        for (int i = 10; i <= 15; i++) step(1'b1, WIDTH'(i), 1'b0, '0);

        // Delay 4 with toggling enable
        step(1'b0, '0, 1'b1, 5'd4);
        seq = 36'd100;
        for (int i = 0; i < 24; i++) begin
            step(i[0] == 1'b0, seq, 1'b0, '0);
            if (i[0] == 1'b0) seq = seq + 36'd1;
        end

        // Rejected loads while running, with and without en
        step(1'b1, 36'd200, 1'b1, 5'd0);
        step(1'b1, 36'd201, 1'b1, 5'd17);
        step(1'b0, 36'd202, 1'b1, 5'd31);
        for (int i = 0; i < 4; i++) step(1'b1, 36'd203 + WIDTH'(i), 1'b0, '0);

        // Maximum delay with wrap-around, then reload of the same delay
        step(1'b1, 36'h0_FFFF_0000, 1'b1, 5'd16);
        for (int i = 0; i < 40; i++) step(1'b1, 36'h9_0000_0000 + WIDTH'(i), 1'b0, '0);
        step(1'b1, 36'h3_0000_0000, 1'b1, 5'd16);
        for (int i = 0; i < 20; i++) step(1'b1, 36'h5_0000_0000 + WIDTH'(i), 1'b0, '0);

        // Reset mid-run, then a load during FILL restarts the count
        do_reset();
        step(1'b1, 36'd300, 1'b1, 5'd3);
        step(1'b1, 36'd301, 1'b0, '0);
        step(1'b1, 36'd302, 1'b0, '0);
        step(1'b1, 36'd303, 1'b1, 5'd5);
        for (int i = 0; i < 10; i++) step(1'b1, 36'd310 + WIDTH'(i), 1'b0, '0);

        // Random traffic with occasional (possibly illegal) loads
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, WIDTH'({$urandom, $urandom}),
                 $urandom_range(0, 15) == 0, DEL_W'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_delay.md
TAP_DELAY -- requirements
Module: tap_delay

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 36, giving the data bit width.
REQ-002 The block SHALL provide parameter MAX_DEL, default 16, giving the maximum delay in enabled cycles; legal range 2..256.
REQ-003 The block SHALL provide parameter DEL_W, default 5, giving the del_sel width; it must satisfy 2^DEL_W > MAX_DEL.
REQ-004 The block SHALL provide parameter DEFAULT_DEL, default 1, giving the delay after reset; legal range 1..MAX_DEL.
REQ-005 The block SHALL provide port clk, input, 1 bit: posedge-active clock.
REQ-006 The block SHALL provide port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 The block SHALL provide port en, input, 1 bit: sample enable; the datapath advances only when en=1.
REQ-008 The block SHALL provide port din, input, WIDTH bits: data to be delayed.
REQ-009 The block SHALL provide port del_sel, input, DEL_W bits: requested delay, sampled when del_load=1.
REQ-010 The block SHALL provide port del_load, input, 1 bit: single-cycle delay-change request.
REQ-011 The block SHALL provide port dout, output, WIDTH bits: delayed data.
REQ-012 The block SHALL provide port dout_vld, output, 1 bit: dout is aligned to the current delay.
REQ-013 The block SHALL provide port del_busy, output, 1 bit: the block is refilling after reset or a delay change.
REQ-014 The block SHALL provide port del_err, output, 1 bit: one-cycle pulse on a rejected del_load.

Function
REQ-015 The datapath SHALL store samples in a circular buffer of MAX_DEL entries; the write pointer advances by one per en=1 cycle and wraps from MAX_DEL-1 to 0.
REQ-016 With current delay D and en=1, dout after the edge sampling din SHALL equal the din sampled D-1 enabled edges earlier; D=1 behaves as a single register.
REQ-017 The fill counter SHALL increment on each en=1 edge, saturate at MAX_DEL, and clear on reset or an accepted load.
REQ-018 The FSM SHALL have two states, FILL and RUN; del_busy=1 in FILL; dout_vld=1 only in RUN.
REQ-019 The FSM SHALL move FILL->RUN on the edge where the fill counter reaches D; that edge is the one sampling the D-th post-load sample.
REQ-020 In FILL, dout SHALL be 0.
REQ-021 A del_load with 1<=del_sel<=MAX_DEL SHALL be accepted: D<=del_sel, fill counter<=0, state<=FILL, all on the same edge.
REQ-022 The din sampled in the cycle of an accepted load SHALL be written to the buffer but not counted.
REQ-023 A del_load with del_sel=0 or del_sel>MAX_DEL SHALL be rejected: D, state and counter unchanged.
REQ-024 A del_load accepted during FILL SHALL restart the fill with the new D.
REQ-025 A del_load with del_sel equal to the current D SHALL still be accepted and SHALL restart the fill.
REQ-026 With en=0, the write pointer, counter, dout and dout_vld SHALL hold; del_load SHALL still be processed.

Reset
REQ-027 rst_n=0 SHALL immediately clear dout, dout_vld, del_err, the write pointer and the fill counter, and set D=DEFAULT_DEL, state FILL and del_busy=1.
REQ-028 Buffer contents SHALL need no reset, because they are masked by FILL.
REQ-029 Reset asserted mid-operation SHALL abort any fill or pending load with no residual state.

Configuration
REQ-030 With macro TAP_DELAY_ERR_EN defined, del_err SHALL pulse high for exactly one cycle on the edge after each rejected del_load.
REQ-031 Without TAP_DELAY_ERR_EN, del_err SHALL be tied 0, the port SHALL remain present, and rejected loads SHALL still be ignored silently.

Verification
REQ-032 Reset release, DEFAULT_DEL=1, en=1, din=1,2,3 -> dout=1 with dout_vld=1 after the first edge, then 2, 3.
REQ-033 Load del_sel=3, then en=1 with din=10,11,12,13 -> dout_vld rises at the 3rd edge with dout=10, then 11; del_busy=1 for the first two edges.
REQ-034 D=4, en toggling 1,0,1,0..., din incrementing per enabled cycle -> dout changes only on enabled edges and lags by 3 enabled samples; dout_vld is not lost.
REQ-035 del_sel=0 and del_sel=MAX_DEL+1 loads while in RUN -> dout_vld stays 1, D is unchanged, and del_err pulses once per load (macro defined) or stays 0 (undefined).
REQ-036 D=MAX_DEL=16, 40 enabled samples -> wrap-around is correct, with dout = din-15 continuously.
REQ-037 Reset pulse mid-RUN, then a second load with del_sel=5 issued 2 cycles into FILL -> all outputs are 0 during reset, and dout_vld rises exactly 5 enabled edges after the second load.
